// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, idle-high line, centre-of-bit sampling.
// Define UART_RX_PARITY_EN for 8E1 frames with a live parity_err_o.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       rx_done_o,
  output logic       frame_err_o,
  output logic       parity_err_o
);

  localparam logic [15:0] CNT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_e;

  logic        rx_meta_q, rx_s_q, rx_prev_q;
  state_e      state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;
  logic        perr_q, perr_d;
  logic        par_bad_q;
`ifdef UART_RX_PARITY_EN
  logic        par_bad_d;
`endif

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Reset to the idle level so release never looks like a start edge.
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches are inferred.
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 16'd1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (rx_prev_q && !rx_s_q) state_d = ST_START;
      end
      ST_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          state_d   = rx_s_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_cnt_q] = rx_s_q;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          par_bad_d = rx_s_q ^ (^shift_q);
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          perr_d    = par_bad_q;
          if (rx_s_q) begin
            state_d = ST_IDLE;
            if (!par_bad_q) begin
              data_d = shift_q;
              done_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        clk_cnt_d = '0;
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_bad_q <= 1'b0;
    else        par_bad_q <= par_bad_d;
  end
`else
  assign par_bad_q = 1'b0;
`endif

  assign data_o       = data_q;
  assign rx_done_o    = done_q;
  assign frame_err_o  = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16; a behavioural serializer stands in for uart_tx.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Edges from rx_i falling to rx_done_o visible: 3 (sync + edge detect) + half bit + 9 (or 10) bits.
  localparam int EXP_LAT = 3 + CPB / 2 + (9 + PAR_BITS) * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_i;
  logic [7:0] data_o;
  logic       rx_done_o, frame_err_o, parity_err_o;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .rx_done_o    (rx_done_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
  int last_done_cyc = 0;
  int fall_cyc = 0;
  logic [7:0] done_log [0:15];

  always @(posedge clk) cyc <= cyc + 1;

  // Counts high cycles of each strobe, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rx_done_o === 1'b1) begin
        done_log[done_cnt[3:0]] = data_o;
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (frame_err_o === 1'b1)  ferr_cnt++;
      if (parity_err_o === 1'b1) perr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_i = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Caller is aligned #1 after a rising edge; par_flip=1 sends the wrong (odd) parity.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_flip);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`else
    if (par_flip) rx_i = 1'b1;
`endif
    drive_bit(stop_b);
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int d0, f0, p0;

  initial begin
    rx_i  = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_data",   data_o,       8'h00);
    check("reset_done",   rx_done_o,    1'b0);
    check("reset_ferr",   frame_err_o,  1'b0);
    check("reset_perr",   parity_err_o, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(8);

    // Single good frame with exact latency
    send_frame(8'h55, 1'b1, 1'b0);
    idle(4);
    check("good55_done_cnt", done_cnt, 1);
    check("good55_data",     done_log[0], 8'h55);
    check("good55_latency",  last_done_cyc - fall_cyc, EXP_LAT);
    check("good55_ferr",     ferr_cnt, 0);
    check("good55_perr",     perr_cnt, 0);
    check("good55_hold",     data_o, 8'h55);

    // Back-to-back frames, no idle gap between them
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    idle(4);
    check("b2b_done_cnt", done_cnt, 3);
    check("b2b_first",    done_log[1], 8'hA3);
    check("b2b_second",   done_log[2], 8'h00);

    // Start glitch of 3 cycles
    rx_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(3 * CPB);
    check("glitch_done", done_cnt, 3);
    check("glitch_ferr", ferr_cnt, 0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(4);
    check("after_glitch_done", done_cnt, 4);
    check("after_glitch_data", data_o, 8'hFF);

    // Framing error followed by a 20-bit break
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    rx_i = 1'b0;
    repeat (20 * CPB) @(posedge clk);
    #1;
    check("ferr_count",     ferr_cnt, f0 + 1);
    check("ferr_no_done",   done_cnt, d0);
    check("ferr_data_hold", data_o, 8'hFF);
    idle(4 * CPB);
    check("break_release_ferr", ferr_cnt, f0 + 1);
    check("break_release_done", done_cnt, d0);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(4);
    check("after_break_done", done_cnt, d0 + 1);
    check("after_break_data", data_o, 8'h81);

    // Reset in the middle of bit 4 of 0xF8 (line high from bit 3 on, so no later falling edge)
    d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i == 3);
    rx_i = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (CPB / 2 - 1) @(posedge clk);
    #1;
    for (int i = 5; i < 8; i++) drive_bit(1'b1);
`ifdef UART_RX_PARITY_EN
    drive_bit(1'b1);
`endif
    drive_bit(1'b1);
    idle(2 * CPB);
    check("midreset_no_done", done_cnt, d0);
    check("midreset_no_ferr", ferr_cnt, f0);
    check("midreset_data",    data_o, 8'h00);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    idle(4);
    check("parity_err_pulse", perr_cnt, p0 + 1);
    check("parity_no_done",   done_cnt, d0);
    check("parity_data_hold", data_o, 8'h00);
`else
    send_frame(8'h07, 1'b1, 1'b0);
    idle(4);
    check("noparity_perr",  perr_cnt, p0);
    check("noparity_done",  done_cnt, d0 + 1);
    check("noparity_data",  data_o, 8'h07);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
